// File: rtl/sw_hex_top.sv
// Switch/HEX demo top: live SW value on HEX2..HEX0 and LEDR, KEY-controlled capture register on HEX5..HEX3.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros in each 3-digit group.
`timescale 1ns/1ps
module sw_hex_top #(
    parameter int SYNC_STAGES    = 2,
    parameter bit HEX_ACTIVE_LOW = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);

    localparam logic [6:0] SEG_BLANK = HEX_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0] SEG_ZERO  = HEX_ACTIVE_LOW ? 7'h40 : 7'h3F;

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("sw_hex_top: SYNC_STAGES must be at least 2");
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return HEX_ACTIVE_LOW ? seg : ~seg;
    endfunction

    // Returns {digit2, digit1, digit0} segment patterns for one 10-bit value.
    function automatic logic [20:0] group_disp(input logic [9:0] value);
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
        logic [6:0] s2;
        logic [6:0] s1;
        logic [6:0] s0;
        d2 = {2'b00, value[9:8]};
        d1 = value[7:4];
        d0 = value[3:0];
        s0 = seg_decode(d0);
`ifdef LEADING_ZERO_BLANK_EN
        if (d2 == 4'h0) begin
            s2 = SEG_BLANK;
        end else begin
            s2 = seg_decode(d2);
        end
        if ((d2 == 4'h0) && (d1 == 4'h0)) begin
            s1 = SEG_BLANK;
        end else begin
            s1 = seg_decode(d1);
        end
`else
        s2 = seg_decode(d2);
        s1 = seg_decode(d1);
`endif
        return {s2, s1, s0};
    endfunction

    logic [1:0] r_rst_sync;
    logic       w_rst_n;
    logic [9:0] r_sw_sync  [SYNC_STAGES];
    logic [3:1] r_key_sync [SYNC_STAGES];
    logic [9:0] w_sw;
    logic [3:1] w_key;
    logic [3:1] r_key_prev;
    logic [3:1] w_press;
    logic [9:0] r_cap;
    logic [9:0] w_cap_next;
    logic [20:0] w_live_segs;
    logic [20:0] w_cap_segs;
    logic [6:0] r_hex0;
    logic [6:0] r_hex1;
    logic [6:0] r_hex2;
    logic [6:0] r_hex3;
    logic [6:0] r_hex4;
    logic [6:0] r_hex5;
    logic [9:0] r_ledr;

    // Reset asserts immediately with KEY[0] and releases two clock edges later.
    always_ff @(posedge CLOCK_50 or negedge KEY[0]) begin
        if (!KEY[0]) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Board input synchronisers; keys rest at 1 so reset release cannot look like a press.
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sw_sync[i]  <= 10'd0;
                r_key_sync[i] <= 3'b111;
            end
        end else begin
            r_sw_sync[0]  <= SW;
            r_key_sync[0] <= KEY[3:1];
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sw_sync[i]  <= r_sw_sync[i-1];
                r_key_sync[i] <= r_key_sync[i-1];
            end
        end
    end

    assign w_sw    = r_sw_sync[SYNC_STAGES-1];
    assign w_key   = r_key_sync[SYNC_STAGES-1];
    assign w_press = r_key_prev & ~w_key;

    // One capture action per cycle: clear, then load, then increment.
    always_comb begin
        w_cap_next = r_cap;
        if (w_press[2]) begin
            w_cap_next = 10'd0;
        end else if (w_press[1]) begin
            w_cap_next = w_sw;
        end else if (w_press[3]) begin
            w_cap_next = r_cap + 10'd1;
        end else begin
            w_cap_next = r_cap;
        end
    end

    // Segment patterns for both digit groups.
    always_comb begin
        w_live_segs = group_disp(w_sw);
        w_cap_segs  = group_disp(r_cap);
    end

    // Capture state, edge-detect history and all registered board outputs.
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_key_prev <= 3'b111;
            r_cap      <= 10'd0;
            r_ledr     <= 10'd0;
            r_hex0     <= SEG_ZERO;
            r_hex1     <= SEG_ZERO;
            r_hex2     <= SEG_ZERO;
            r_hex3     <= SEG_ZERO;
            r_hex4     <= SEG_ZERO;
            r_hex5     <= SEG_ZERO;
        end else begin
            r_key_prev <= w_key;
            r_cap      <= w_cap_next;
            r_ledr     <= w_sw;
            r_hex2     <= w_live_segs[20:14];
            r_hex1     <= w_live_segs[13:7];
            r_hex0     <= w_live_segs[6:0];
            r_hex5     <= w_cap_segs[20:14];
            r_hex4     <= w_cap_segs[13:7];
            r_hex3     <= w_cap_segs[6:0];
        end
    end

    assign HEX0 = r_hex0;
    assign HEX1 = r_hex1;
    assign HEX2 = r_hex2;
    assign HEX3 = r_hex3;
    assign HEX4 = r_hex4;
    assign HEX5 = r_hex5;
    assign LEDR = r_ledr;

endmodule

// File: tb/tb_sw_hex_top.sv
// Bench for sw_hex_top: cycle model from the behavioural rules plus directed literal checks.
`timescale 1ns/1ps
module tb_sw_hex_top;

    localparam int NS  = 2;
    localparam bit HAL = 1'b1;
    localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [6:0] BLK = HAL ? 7'h7F : 7'h00;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif

    logic       clk;
    logic [3:0] key;
    logic [9:0] sw;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [9:0] ledr;

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    sw_hex_top #(.SYNC_STAGES(NS), .HEX_ACTIVE_LOW(HAL)) dut (
        .CLOCK_50(clk), .KEY(key), .SW(sw),
        .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5),
        .LEDR(ledr)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        return HAL ? SEG_TAB[d] : ~SEG_TAB[d];
    endfunction

    function automatic logic [20:0] disp3(input logic [9:0] v);
        int d2, d1, d0;
        logic [6:0] s2, s1, s0;
        d2 = int'(v) / 256;
        d1 = (int'(v) / 16) % 16;
        d0 = int'(v) % 16;
        s2 = seg_of(d2);
        s1 = seg_of(d1);
        s0 = seg_of(d0);
`ifdef LEADING_ZERO_BLANK_EN
        if (d2 == 0) s2 = BLK;
        if (d2 == 0 && d1 == 0) s1 = BLK;
`endif
        return {s2, s1, s0};
    endfunction

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk3(input string nm, input logic [6:0] a2, input logic [6:0] a1, input logic [6:0] a0,
                        input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
        chk({nm, "_d2"}, {3'b000, a2}, {3'b000, e2});
        chk({nm, "_d1"}, {3'b000, a1}, {3'b000, e1});
        chk({nm, "_d0"}, {3'b000, a0}, {3'b000, e0});
    endtask

    // Model: history of input samples per active clock edge; synchronised view is NS edges old.
    logic [12:0] hist[$];
    logic [9:0]  m_cap, m_ledr;
    logic [20:0] m_live, m_capd;
    int          m_hold;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i <= NS; i++) hist.push_back({3'b111, 10'd0});
        m_cap  = 10'd0;
        m_ledr = 10'd0;
        m_live = {seg_of(0), seg_of(0), seg_of(0)};
        m_capd = {seg_of(0), seg_of(0), seg_of(0)};
        m_hold = 0;
    endtask

    task automatic model_step();
        logic [12:0] cur, prev;
        logic [2:0]  press;
        if (m_hold < 2) begin
            m_hold++;
        end else begin
            cur   = hist[hist.size() - NS];
            prev  = hist[hist.size() - NS - 1];
            press = prev[12:10] & ~cur[12:10];
            m_ledr = cur[9:0];
            m_live = disp3(cur[9:0]);
            m_capd = disp3(m_cap);
            if (press[1])      m_cap = 10'd0;
            else if (press[0]) m_cap = cur[9:0];
            else if (press[2]) m_cap = m_cap + 10'd1;
            hist.push_back({key[3:1], sw});
            void'(hist.pop_front());
        end
    endtask

    // Compare process: inputs only change at negedge+1, so values seen here are those of the last posedge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (done) break;
            if (!key[0]) model_reset();
            else model_step();
            chk3("live", hex2, hex1, hex0, m_live[20:14], m_live[13:7], m_live[6:0]);
            chk3("capt", hex5, hex4, hex3, m_capd[20:14], m_capd[13:7], m_capd[6:0]);
            chk("ledr", ledr, m_ledr);
        end
    end

    task automatic set_sw(input logic [9:0] v);
        @(negedge clk); #1 sw = v;
    endtask

    task automatic press(input logic [3:1] mask, input int hold);
        @(negedge clk); #1 key[3:1] = ~mask;
        repeat (hold) @(negedge clk);
        #1 key[3:1] = 3'b111;
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        key = 4'b1111;
        sw  = 10'd0;
        #3 key[0] = 1'b0;
        // 1: reset and release with SW=0, no false press
        repeat (4) @(negedge clk);
        #1 key[0] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk3("rst_live", hex2, hex1, hex0, LZ, LZ, 7'h40);
        chk3("rst_capt", hex5, hex4, hex3, LZ, LZ, 7'h40);
        chk("rst_ledr", ledr, 10'h000);

        // 2: live path latency
        set_sw(10'h2A5);
        repeat (2) @(posedge clk);
        #1 chk("lat2_ledr", ledr, 10'h000);
        @(posedge clk);
        #1;
        chk3("lat3_live", hex2, hex1, hex0, 7'h24, 7'h08, 7'h12);
        chk("lat3_ledr", ledr, 10'h2A5);
        chk3("lat3_capt", hex5, hex4, hex3, LZ, LZ, 7'h40);

        // 3: capture 3FF then increment wraps to 0
        set_sw(10'h3FF);
        repeat (4) @(posedge clk);
        press(3'b001, 2);
        chk3("cap3ff", hex5, hex4, hex3, 7'h30, 7'h0E, 7'h0E);
        press(3'b100, 1);
        chk3("wrap", hex5, hex4, hex3, LZ, LZ, 7'h40);

        // 4: priorities and no auto-repeat
        set_sw(10'h123);
        repeat (4) @(posedge clk);
        press(3'b001, 3);
        chk3("cap123", hex5, hex4, hex3, 7'h79, 7'h24, 7'h30);
        press(3'b011, 3);
        chk3("clr_wins", hex5, hex4, hex3, LZ, LZ, 7'h40);
        press(3'b100, 100);
        chk3("hold_inc", hex5, hex4, hex3, LZ, LZ, 7'h79);
        press(3'b101, 2);
        chk3("cap_beats_inc", hex5, hex4, hex3, 7'h79, 7'h24, 7'h30);

        // 5: asynchronous reset mid-operation
        set_sw(10'h155);
        repeat (4) @(posedge clk);
        press(3'b001, 2);
        chk3("cap155", hex5, hex4, hex3, 7'h79, 7'h12, 7'h12);
        @(posedge clk);
        #2 key[0] = 1'b0;
        #1;
        chk3("arst_live", hex2, hex1, hex0, 7'h40, 7'h40, 7'h40);
        chk3("arst_capt", hex5, hex4, hex3, 7'h40, 7'h40, 7'h40);
        chk("arst_ledr", ledr, 10'h000);
        repeat (3) @(negedge clk);
        #1 key[0] = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk3("post_arst_capt", hex5, hex4, hex3, LZ, LZ, 7'h40);

        // 6: leading-zero cases
        set_sw(10'h005);
        repeat (3) @(posedge clk);
        #1 chk3("sw005", hex2, hex1, hex0, LZ, LZ, 7'h12);
        set_sw(10'h050);
        repeat (3) @(posedge clk);
        #1 chk3("sw050", hex2, hex1, hex0, LZ, 7'h12, 7'h40);
        set_sw(10'h100);
        repeat (3) @(posedge clk);
        #1 chk3("sw100", hex2, hex1, hex0, 7'h79, 7'h40, 7'h40);
        set_sw(10'h000);
        repeat (3) @(posedge clk);
        #1 chk3("sw000", hex2, hex1, hex0, LZ, LZ, 7'h40);

        repeat (5) @(posedge clk);
        done = 1'b1;
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
